// File: rtl/uart_echo_master.sv
// rtl/uart_echo_master.sv - register-bus master that echoes UART RX bytes back to TX
module uart_echo_master #(
  parameter int SETTLE_CYC = 2,
  parameter bit UPCASE     = 1'b0,
  parameter bit INIT_RST   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        cs,
  output logic        we,
  output logic [1:0]  reg_sel,
  output logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] byte_cnt,
  output logic [7:0]  last_byte
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_RXST, ST_RD, ST_GAP, ST_TXST, ST_WR, ST_SETTLE
  } state_t;

  localparam state_t RST_STATE = state_t'(INIT_RST ? ST_INIT : ST_IDLE);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    data_q;

  // Only the low byte carries data; status polls use bit 0 of it.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^rdata[15:8];

  function automatic logic [7:0] xform(input logic [7:0] b);
    if (UPCASE && (b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
    return b;
  endfunction

  // Next-state decision; status reads are taken from rdata as the poll cycle ends.
  always_comb begin
    nxt = state;
    case (state)
      // INIT holds one idle cycle after reset release, then one soft-reset write.
      ST_INIT:   nxt = cs ? ST_SETTLE : ST_INIT;
      ST_IDLE:   nxt = en ? ST_RXST : ST_IDLE;
      ST_RXST:   nxt = !rdata[0] ? ST_RD : (en ? ST_RXST : ST_IDLE);
      ST_RD:     nxt = ST_GAP;
      ST_GAP:    nxt = (cnt == CW'(1)) ? ST_TXST : ST_GAP;
      ST_TXST:   nxt = !rdata[0] ? ST_WR : ST_TXST;
      ST_WR:     nxt = ST_SETTLE;
      ST_SETTLE: nxt = (cnt == CW'(1)) ? (en ? ST_RXST : ST_IDLE) : ST_SETTLE;
      default:   nxt = RST_STATE;
    endcase
  end

  // State, registered bus outputs for the entered state, settle timer and byte bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST_STATE;
      cs        <= 1'b0;
      we        <= 1'b0;
      reg_sel   <= 2'b00;
      wdata     <= 16'h0000;
      busy      <= 1'b0;
      cnt       <= '0;
      data_q    <= 8'h00;
      byte_cnt  <= 16'h0000;
      last_byte <= 8'h00;
    end else begin
      state   <= nxt;
      busy    <= (nxt != ST_IDLE);
      cs      <= 1'b0;
      we      <= 1'b0;
      reg_sel <= 2'b00;
      wdata   <= 16'h0000;
      case (nxt)
        ST_INIT: begin cs <= 1'b1; we <= 1'b1; reg_sel <= 2'b01; end
        ST_RXST: begin cs <= 1'b1; reg_sel <= 2'b11; end
        ST_RD:   begin cs <= 1'b1; reg_sel <= 2'b01; end
        ST_TXST: begin cs <= 1'b1; reg_sel <= 2'b10; end
        ST_WR: begin
          cs      <= 1'b1;
          we      <= 1'b1;
          reg_sel <= 2'b00;
          wdata   <= {8'h00, data_q};
        end
        default: ;
      endcase

      if ((nxt != state) && ((nxt == ST_GAP) || (nxt == ST_SETTLE)))
        cnt <= CW'(SETTLE_CYC);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);

      if (state == ST_RD)
        data_q <= xform(rdata[7:0]);

      if (state == ST_WR) begin
        byte_cnt  <= byte_cnt + 16'h0001;
        last_byte <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_master.sv
// tb/tb_uart_echo_master.sv - directed bench for uart_echo_master with a behavioural UART register model
module tb_uart_echo_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        cs;
  logic        we;
  logic [1:0]  reg_sel;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] byte_cnt;
  logic [7:0]  last_byte;

  int n_cmp = 0;
  int n_bad = 0;

  // UART controller model state
  logic [7:0] rx_mem [0:15];
  int         rx_head = 0;
  int         rx_tail = 0;
  logic       tx_full;
  logic [7:0] tx_log [0:63];
  int         tx_cnt = 0;
  int         rd_cnt = 0;
  int         srst_cnt = 0;
  int         full_poll_cnt = 0;

  always #5 clk = ~clk;

  uart_echo_master #(.SETTLE_CYC(2), .UPCASE(1'b1), .INIT_RST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .en(en),
    .cs(cs), .we(we), .reg_sel(reg_sel), .wdata(wdata), .rdata(rdata),
    .busy(busy), .byte_cnt(byte_cnt), .last_byte(last_byte)
  );

  // combinational register read data
  always_comb begin
    rdata = 16'h0000;
    case (reg_sel)
      2'b11: rdata[0] = (rx_head == rx_tail);
      2'b10: rdata[0] = tx_full;
      2'b01: rdata = {8'h00, rx_mem[rx_head[3:0]]};
      default: ;
    endcase
  end

  // bus access bookkeeping
  always @(posedge clk) begin
    if (cs && !we && reg_sel == 2'b01) begin
      rx_head <= rx_head + 1;
      rd_cnt  <= rd_cnt + 1;
    end
    if (cs && we && reg_sel == 2'b00) begin
      tx_log[tx_cnt] <= wdata[7:0];
      tx_cnt <= tx_cnt + 1;
    end
    if (cs && we && reg_sel == 2'b01) srst_cnt <= srst_cnt + 1;
    if (cs && !we && reg_sel == 2'b10 && tx_full) full_poll_cnt <= full_poll_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_tail[3:0]] = b;
    rx_tail = rx_tail + 1;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 100 && busy; i++) tick();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_tx(input string tag, input int target);
    int i;
    for (i = 0; i < 300 && tx_cnt < target; i++) tick();
    chk(tag, tx_cnt, target);
  endtask

  int base_tx, base_rd, base_fp, i;

  initial begin
    reset = 1'b0;
    en = 1'b0;
    tx_full = 1'b0;
    repeat (3) tick();
    chk("rst_cs", {31'd0, cs}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte_cnt", byte_cnt, 32'd0);
    chk("rst_last_byte", last_byte, 32'd0);
    chk("rst_wdata", wdata, 32'd0);

    // 1: init soft reset
    reset = 1'b1;
    tick();
    chk("init_bus", {29'd0, cs, we, reg_sel}, 32'b1101);
    chk("init_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("init_settle1", {30'd0, cs, busy}, 32'b01);
    tick();
    chk("init_settle2", {30'd0, cs, busy}, 32'b01);
    tick();
    chk("init_idle", {30'd0, cs, busy}, 32'b00);
    chk("init_srst_cnt", srst_cnt, 32'd1);

    // 2: single echo, 8-cycle loop
    push_rx(8'h41);
    en = 1'b1;
    tick();
    chk("t2_rxst", {29'd0, cs, we, reg_sel}, 32'b1011);
    tick();
    chk("t2_rd", {29'd0, cs, we, reg_sel}, 32'b1001);
    repeat (3) tick();
    chk("t2_txst", {29'd0, cs, we, reg_sel}, 32'b1010);
    tick();
    chk("t2_wr", {29'd0, cs, we, reg_sel}, 32'b1100);
    chk("t2_wdata", wdata, 32'h0041);
    tick();
    chk("t2_byte_cnt", byte_cnt, 32'd1);
    chk("t2_last_byte", last_byte, 32'h41);
    repeat (2) tick();
    chk("t2_rxst_again", {29'd0, cs, we, reg_sel}, 32'b1011);
    chk("t2_rd_cnt", rd_cnt, 32'd1);
    en = 1'b0;
    wait_idle("t2_idle");

    // 3: upper-casing
    base_tx = tx_cnt;
    push_rx(8'h61);
    push_rx(8'h7B);
    push_rx(8'h5A);
    en = 1'b1;
    wait_tx("t3_tx_count", base_tx + 3);
    chk("t3_b0", tx_log[base_tx], 32'h41);
    chk("t3_b1", tx_log[base_tx + 1], 32'h7B);
    chk("t3_b2", tx_log[base_tx + 2], 32'h5A);
    tick();
    chk("t3_byte_cnt", byte_cnt, 32'd4);
    en = 1'b0;
    wait_idle("t3_idle");

    // 4: TX full back-pressure
    base_tx = tx_cnt;
    base_rd = rd_cnt;
    base_fp = full_poll_cnt;
    tx_full = 1'b1;
    push_rx(8'h33);
    en = 1'b1;
    for (i = 0; i < 200 && full_poll_cnt < base_fp + 50; i++) tick();
    chk("t4_full_polls", full_poll_cnt - base_fp, 32'd50);
    chk("t4_no_write", tx_cnt - base_tx, 32'd0);
    chk("t4_one_read", rd_cnt - base_rd, 32'd1);
    tx_full = 1'b0;
    tick();
    chk("t4_wr", {29'd0, cs, we, reg_sel}, 32'b1100);
    chk("t4_wdata", wdata, 32'h0033);
    repeat (4) tick();
    chk("t4_rd_after", rd_cnt - base_rd, 32'd1);
    en = 1'b0;
    wait_idle("t4_idle");

    // 5: en dropped during GAP
    base_tx = tx_cnt;
    base_rd = rd_cnt;
    push_rx(8'h62);
    en = 1'b1;
    for (i = 0; i < 50 && rd_cnt == base_rd; i++) tick();
    en = 1'b0;
    push_rx(8'h63);
    wait_tx("t5_tx_count", base_tx + 1);
    chk("t5_byte", tx_log[base_tx], 32'h42);
    wait_idle("t5_idle");
    repeat (20) tick();
    chk("t5_no_read", rd_cnt - base_rd, 32'd1);
    chk("t5_pending", rx_tail - rx_head, 32'd1);
    en = 1'b1;
    wait_tx("t5_tx_resume", base_tx + 2);
    chk("t5_byte2", tx_log[base_tx + 1], 32'h43);
    en = 1'b0;
    wait_idle("t5_idle2");

    // 6: async reset during WR, then counter wrap
    base_tx = tx_cnt;
    push_rx(8'h44);
    en = 1'b1;
    for (i = 0; i < 50 && !(cs && we && reg_sel == 2'b00); i++) tick();
    chk("t6_in_wr", {29'd0, cs, we, reg_sel}, 32'b1100);
    #2 reset = 1'b0;
    en = 1'b0;
    #1;
    chk("t6_cs_abort", {31'd0, cs}, 32'd0);
    chk("t6_byte_cnt", byte_cnt, 32'd0);
    tick();
    tick();
    chk("t6_no_write", tx_cnt - base_tx, 32'd0);
    reset = 1'b1;
    repeat (6) tick();
    chk("t6_srst_cnt", srst_cnt, 32'd2);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    force u_dut.byte_cnt = 16'hFFFF;
    #1 release u_dut.byte_cnt;
    tick();
    chk("t6_preset", byte_cnt, 32'hFFFF);
    base_tx = tx_cnt;
    push_rx(8'h7A);
    en = 1'b1;
    wait_tx("t6_tx_count", base_tx + 1);
    tick();
    chk("t6_wrap", byte_cnt, 32'h0000);
    chk("t6_last_byte", last_byte, 32'h5A);
    en = 1'b0;
    wait_idle("t6_idle2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
